slc3_control_unit: RTL and testbench
====================================

// Module: slc3_control_unit
// PURPOSE
//  Moore FSM that sequences the SLC3 datapath: fetch, decode and execute for ADD/AND/NOT/BR/JMP/JSR/LDR/STR/PAUSE.
//  Drives every load, gate and mux select of the datapath, plus the memory OE/WE strobes.
//  Sits between the top-level Run/Continue switches, the IR/BEN outputs of the datapath and SRAM.
//  Inserts a programmable number of wait cycles on every memory access.
// PARAMETERS
//  MEM_WAIT  2  memory wait cycles per access, legal range 1..15 (Mem_OE/Mem_WE held for exactly MEM_WAIT cycles)
// PORTS
//  Clk                          in   1  system clock; all state updates on the rising edge
//  Reset                        in   1  asynchronous, active-low; 0 forces state Halted
//  Run                          in   1  start execution from Halted (level, sampled each cycle)
//  Continue                     in   1  resume from PAUSE (level, sampled each cycle)
//  Opcode                       in   4  IR[15:12]
//  IR_5                         in   1  IR[5]: immediate select for ADD/AND
//  IR_11                        in   1  IR[11]: JSR (1) vs JSRR (0)
//  BEN                          in   1  registered branch enable from the datapath
//  LD_MAR,LD_MDR,LD_IR,LD_BEN   out  1  register loads
//  LD_CC,LD_REG,LD_PC,LD_LED    out  1  register loads
//  GatePC,GateMDR,GateALU,GateMARMUX  out 1  bus gates; at most one high in any cycle
//  SR2MUX,ADDR1MUX,DRMUX,SR1MUX out  1  0=SEXT(IR[4:0])/PC/R7/IR[11:9]; 1=SR2/SR1/IR[11:9]/IR[8:6]
//  MARMUX                       out  1  tied 0 (adder path)
//  PCMUX                        out  2  00=PC+1 01=adder 10=bus
//  ADDR2MUX                     out  2  00=0 01=off6 10=off9 11=off11
//  ALUK                         out  2  00=ADD 01=AND 10=NOT A 11=PASS A
//  MIO_EN                       out  1  1=MDR loads from memory, 0=MDR loads from bus
//  Mem_OE,Mem_WE                out  1  active-high memory read/write strobes
// BEHAVIOUR
//  Reset
//   - Reset=0 at any time (including mid-instruction or mid-wait) -> state Halted, wait counter 0.
//   - All outputs are 0 in Halted.
//   - No memory strobe may remain asserted in the cycle after Reset falls.
//  Outputs
//   - Pure Moore: outputs are a function of (state, wait counter) only.
//   - Every output not listed for a state is 0.
//  Fetch
//   - Halted -> S18 when Run=1.
//   - S18: GatePC, LD_MAR, PCMUX=00, LD_PC.
//   - S33: Mem_OE, MIO_EN. Held MEM_WAIT cycles; LD_MDR only on the last cycle.
//   - S35: GateMDR, LD_IR.
//   - S32: LD_BEN; dispatch on Opcode.
//  Execute (DRMUX=1, SR1MUX=1 unless stated)
//   - ADD (0001) S1 / AND (0101) S5: SR2MUX=~IR_5, ALUK=00/01, GateALU, LD_REG, LD_CC -> S18.
//   - NOT (1001) S9: ALUK=10, GateALU, LD_REG, LD_CC -> S18.
//   - BR (0000) S0: BEN=1 -> S22, else -> S18.
//       S22: ADDR1MUX=0, ADDR2MUX=10, PCMUX=01, LD_PC -> S18.
//   - JMP (1100) S12: SR1MUX=1, ALUK=11, GateALU, PCMUX=10, LD_PC -> S18.
//   - JSR (0100) S4: GatePC, DRMUX=0, LD_REG -> S21.
//       S21: IR_11=1 -> ADDR1MUX=0, ADDR2MUX=11; IR_11=0 -> ADDR1MUX=1, ADDR2MUX=00; PCMUX=01, LD_PC -> S18.
//   - LDR (0110) S6: ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR -> S25.
//       S25: wait as S33 -> S27.
//       S27: GateMDR, LD_REG, LD_CC -> S18.
//   - STR (0111) S7: as S6 -> S23.
//       S23: SR1MUX=0, ALUK=11, GateALU, MIO_EN=0, LD_MDR -> S16.
//       S16: Mem_WE for MEM_WAIT cycles -> S18.
//   - PAUSE (1101) P1: LD_LED; stay while Continue=0; Continue=1 -> P2.
//       P2: stay while Continue=1; Continue=0 -> S18 (one instruction per press).
//   - Any other opcode -> S18 (treated as NOP).
//  Run
//   - Run is ignored outside Halted. Only Reset returns the FSM to Halted.
//  Wait counter
//   - 4 bits. Clears on entry to each wait state and counts up.
//   - Exits the wait state when counter == MEM_WAIT-1.
//   - MEM_WAIT=1 gives a single-cycle access.
// STRUCTURE
//  slc3_ctrl_pkg
//   - state_t enum, opcode localparams, PCMUX/ADDR2MUX/ALUK encodings.
//   - Shared with the datapath and the testbench.
//  Sub-module: mem_wait_counter
//   - Inputs: clr, en. Output: done.
//   - Parameterised by MEM_WAIT.
// TESTING
//  1. Reset=0 in S33 with Mem_OE=1 -> next cycle all outputs 0, state Halted; Run=1 -> S18 after one clock.
//  2. Run=1 with MEM_WAIT=2 -> S18,S33,S33,S35,S32 sequence. Mem_OE high for 2 cycles; LD_MDR in 2nd cycle only.
//  3. Opcode 0001, IR_5=1 -> S1 with SR2MUX=0, ALUK=00, GateALU=1, LD_REG=1, LD_CC=1; then S18.
//  4. Opcode 0000: BEN=0 -> S0 then S18 with no LD_PC; BEN=1 -> S22 with PCMUX=01, ADDR2MUX=10, LD_PC=1.
//  5. Opcode 0111 -> S7,S23,S16x MEM_WAIT. Mem_WE asserted exactly MEM_WAIT cycles; never together with Mem_OE.
//  6. Opcode 1101 -> LD_LED=1 one cycle; Continue pulses 0->1->0 -> exactly one return to S18.
//     Bus gates checked one-hot-or-zero every cycle.

Source files
------------

// File: rtl/slc3_ctrl_pkg.sv
// Shared SLC3 control definitions: FSM states, opcodes and datapath mux encodings.
// Imported by the control unit, the datapath and the testbench.
package slc3_ctrl_pkg;

   typedef enum logic [4:0] {
      StHalted,
      St18,
      St33,
      St35,
      St32,
      St1,
      St5,
      St9,
      St0,
      St22,
      St12,
      St4,
      St21,
      St6,
      St25,
      St27,
      St7,
      St23,
      St16,
      StP1,
      StP2
   } state_t;

   localparam logic [3:0] OpBr    = 4'b0000;
   localparam logic [3:0] OpAdd   = 4'b0001;
   localparam logic [3:0] OpJsr   = 4'b0100;
   localparam logic [3:0] OpAnd   = 4'b0101;
   localparam logic [3:0] OpLdr   = 4'b0110;
   localparam logic [3:0] OpStr   = 4'b0111;
   localparam logic [3:0] OpNot   = 4'b1001;
   localparam logic [3:0] OpJmp   = 4'b1100;
   localparam logic [3:0] OpPause = 4'b1101;

   localparam logic [1:0] PcmuxInc   = 2'b00;
   localparam logic [1:0] PcmuxAdder = 2'b01;
   localparam logic [1:0] PcmuxBus   = 2'b10;

   localparam logic [1:0] Addr2Zero  = 2'b00;
   localparam logic [1:0] Addr2Off6  = 2'b01;
   localparam logic [1:0] Addr2Off9  = 2'b10;
   localparam logic [1:0] Addr2Off11 = 2'b11;

   localparam logic [1:0] AlukAdd  = 2'b00;
   localparam logic [1:0] AlukAnd  = 2'b01;
   localparam logic [1:0] AlukNot  = 2'b10;
   localparam logic [1:0] AlukPass = 2'b11;

   // States that hold a memory strobe for MEM_WAIT cycles.
   function automatic logic is_wait_state(state_t s);
      return (s == St33) || (s == St25) || (s == St16);
   endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Memory access wait counter: restarts from zero while clr is high, counts while en is high,
// and flags the final cycle of a MEM_WAIT-cycle access.
module mem_wait_counter #(
   parameter int unsigned MEM_WAIT = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic done
);

   localparam logic [3:0] LastCount = 4'(MEM_WAIT - 1);

   logic [3:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = 4'd0;
      end else if (en) begin
         count_d = count_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 4'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == LastCount);

endmodule

// File: rtl/slc3_control_unit.sv
// SLC3 control unit: Moore FSM driving datapath loads, gates, mux selects and memory strobes
// through fetch, decode and execute, with a programmable wait on every memory access.
module slc3_control_unit
   import slc3_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Run,
   input  logic       Continue,
   input  logic [3:0] Opcode,
   input  logic       IR_5,
   input  logic       IR_11,
   input  logic       BEN,
   output logic       LD_MAR,
   output logic       LD_MDR,
   output logic       LD_IR,
   output logic       LD_BEN,
   output logic       LD_CC,
   output logic       LD_REG,
   output logic       LD_PC,
   output logic       LD_LED,
   output logic       GatePC,
   output logic       GateMDR,
   output logic       GateALU,
   output logic       GateMARMUX,
   output logic       SR2MUX,
   output logic       ADDR1MUX,
   output logic       DRMUX,
   output logic       SR1MUX,
   output logic       MARMUX,
   output logic [1:0] PCMUX,
   output logic [1:0] ADDR2MUX,
   output logic [1:0] ALUK,
   output logic       MIO_EN,
   output logic       Mem_OE,
   output logic       Mem_WE
);

   state_t state_q, state_d;
   logic   mem_done;
   logic   in_wait;
   logic   in_exec;

   assign in_wait = is_wait_state(state_q);
   assign in_exec = !(state_q inside {StHalted, St18, St33, St35, St32});
   assign MARMUX  = 1'b0;

   // Counter is held clear outside wait states so it always starts at 0 on entry.
   mem_wait_counter #(
      .MEM_WAIT(MEM_WAIT)
   ) u_wait (
      .clk  (Clk),
      .rst_n(Reset),
      .clr  (!in_wait),
      .en   (in_wait),
      .done (mem_done)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= StHalted;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      LD_MAR     = 1'b0;
      LD_MDR     = 1'b0;
      LD_IR      = 1'b0;
      LD_BEN     = 1'b0;
      LD_CC      = 1'b0;
      LD_REG     = 1'b0;
      LD_PC      = 1'b0;
      LD_LED     = 1'b0;
      GatePC     = 1'b0;
      GateMDR    = 1'b0;
      GateALU    = 1'b0;
      GateMARMUX = 1'b0;
      SR2MUX     = 1'b0;
      ADDR1MUX   = 1'b0;
      DRMUX      = in_exec;
      SR1MUX     = in_exec;
      PCMUX      = PcmuxInc;
      ADDR2MUX   = Addr2Zero;
      ALUK       = AlukAdd;
      MIO_EN     = 1'b0;
      Mem_OE     = 1'b0;
      Mem_WE     = 1'b0;

      unique case (state_q)
         StHalted: begin
            if (Run) state_d = St18;
         end
         St18: begin
            GatePC  = 1'b1;
            LD_MAR  = 1'b1;
            PCMUX   = PcmuxInc;
            LD_PC   = 1'b1;
            state_d = St33;
         end
         St33, St25: begin
            Mem_OE = 1'b1;
            MIO_EN = 1'b1;
            LD_MDR = mem_done;
            if (mem_done) state_d = (state_q == St33) ? St35 : St27;
         end
         St35: begin
            GateMDR = 1'b1;
            LD_IR   = 1'b1;
            state_d = St32;
         end
         St32: begin
            LD_BEN = 1'b1;
            unique case (Opcode)
               OpAdd:   state_d = St1;
               OpAnd:   state_d = St5;
               OpNot:   state_d = St9;
               OpBr:    state_d = St0;
               OpJmp:   state_d = St12;
               OpJsr:   state_d = St4;
               OpLdr:   state_d = St6;
               OpStr:   state_d = St7;
               OpPause: state_d = StP1;
               default: state_d = St18;
            endcase
         end
         St1, St5: begin
            SR2MUX  = ~IR_5;
            ALUK    = (state_q == St1) ? AlukAdd : AlukAnd;
            GateALU = 1'b1;
            LD_REG  = 1'b1;
            LD_CC   = 1'b1;
            state_d = St18;
         end
         St9: begin
            ALUK    = AlukNot;
            GateALU = 1'b1;
            LD_REG  = 1'b1;
            LD_CC   = 1'b1;
            state_d = St18;
         end
         St0: begin
            state_d = BEN ? St22 : St18;
         end
         St22: begin
            ADDR1MUX = 1'b0;
            ADDR2MUX = Addr2Off9;
            PCMUX    = PcmuxAdder;
            LD_PC    = 1'b1;
            state_d  = St18;
         end
         St12: begin
            ALUK    = AlukPass;
            GateALU = 1'b1;
            PCMUX   = PcmuxBus;
            LD_PC   = 1'b1;
            state_d = St18;
         end
         St4: begin
            GatePC  = 1'b1;
            DRMUX   = 1'b0;
            LD_REG  = 1'b1;
            state_d = St21;
         end
         St21: begin
            ADDR1MUX = ~IR_11;
            ADDR2MUX = IR_11 ? Addr2Off11 : Addr2Zero;
            PCMUX    = PcmuxAdder;
            LD_PC    = 1'b1;
            state_d  = St18;
         end
         St6, St7: begin
            ADDR1MUX   = 1'b1;
            ADDR2MUX   = Addr2Off6;
            GateMARMUX = 1'b1;
            LD_MAR     = 1'b1;
            state_d    = (state_q == St6) ? St25 : St23;
         end
         St27: begin
            GateMDR = 1'b1;
            LD_REG  = 1'b1;
            LD_CC   = 1'b1;
            state_d = St18;
         end
         St23: begin
            SR1MUX  = 1'b0;
            ALUK    = AlukPass;
            GateALU = 1'b1;
            MIO_EN  = 1'b0;
            LD_MDR  = 1'b1;
            state_d = St16;
         end
         St16: begin
            Mem_WE = 1'b1;
            if (mem_done) state_d = St18;
         end
         StP1: begin
            LD_LED = 1'b1;
            if (Continue) state_d = StP2;
         end
         StP2: begin
            if (!Continue) state_d = St18;
         end
         default: state_d = StHalted;
      endcase
   end

endmodule

// File: tb/tb_slc3_control_unit.sv
// Directed self-checking bench for slc3_control_unit with MEM_WAIT=2.
module tb_slc3_control_unit;
   import slc3_ctrl_pkg::*;

   logic       Clk = 1'b0;
   logic       Reset, Run, Continue, IR_5, IR_11, BEN;
   logic [3:0] Opcode;
   logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
   logic       GatePC, GateMDR, GateALU, GateMARMUX;
   logic       SR2MUX, ADDR1MUX, DRMUX, SR1MUX, MARMUX, MIO_EN, Mem_OE, Mem_WE;
   logic [1:0] PCMUX, ADDR2MUX, ALUK;

   int checks   = 0;
   int failures = 0;

   always #5 Clk = ~Clk;

   slc3_control_unit #(.MEM_WAIT(2)) dut (
      .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
      .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
      .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
      .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
      .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
      .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX),
      .MARMUX(MARMUX), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
      .MIO_EN(MIO_EN), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
   );

   logic [25:0] outs;
   assign outs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                  GatePC, GateMDR, GateALU, GateMARMUX, SR2MUX, ADDR1MUX, DRMUX, SR1MUX,
                  MARMUX, PCMUX, ADDR2MUX, ALUK, MIO_EN, Mem_OE, Mem_WE};

   localparam logic [25:0] M_LD_MAR = 26'h1 << 25, M_LD_MDR = 26'h1 << 24;
   localparam logic [25:0] M_LD_IR  = 26'h1 << 23, M_LD_BEN = 26'h1 << 22;
   localparam logic [25:0] M_LD_CC  = 26'h1 << 21, M_LD_REG = 26'h1 << 20;
   localparam logic [25:0] M_LD_PC  = 26'h1 << 19, M_LD_LED = 26'h1 << 18;
   localparam logic [25:0] M_G_PC   = 26'h1 << 17, M_G_MDR  = 26'h1 << 16;
   localparam logic [25:0] M_G_ALU  = 26'h1 << 15, M_G_MMUX = 26'h1 << 14;
   localparam logic [25:0] M_SR2    = 26'h1 << 13, M_ADDR1  = 26'h1 << 12;
   localparam logic [25:0] M_DR     = 26'h1 << 11, M_SR1    = 26'h1 << 10;
   localparam logic [25:0] P_ADDER  = 26'h080, P_BUS = 26'h100;
   localparam logic [25:0] A2_OFF6  = 26'h020, A2_OFF9 = 26'h040, A2_OFF11 = 26'h060;
   localparam logic [25:0] K_PASS   = 26'h018;
   localparam logic [25:0] M_MIO    = 26'h4, M_OE = 26'h2, M_WE = 26'h1;
   localparam logic [25:0] EX       = M_DR | M_SR1;

   localparam logic [25:0] O18 = M_LD_MAR | M_LD_PC | M_G_PC;
   localparam logic [25:0] O33 = M_MIO | M_OE;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #2;
   endtask

   task automatic chk_state(input string tag, input state_t s, input logic [25:0] o);
      check({tag, "_st"}, 32'(dut.state_q), 32'(s));
      check({tag, "_out"}, 32'(outs), 32'(o));
   endtask

   // Expects the FSM to be in S18 now; leaves it in S32 with Opcode applied.
   task automatic fetch(input logic [3:0] op);
      Opcode = op;
      chk_state("s18", St18, O18);
      step();
      chk_state("s33_w0", St33, O33);
      step();
      chk_state("s33_w1", St33, O33 | M_LD_MDR);
      step();
      chk_state("s35", St35, M_G_MDR | M_LD_IR);
      step();
      chk_state("s32", St32, M_LD_BEN);
   endtask

   logic mon_en = 1'b0;
   always @(negedge Clk) begin
      if (mon_en && Reset) begin
         check("gate_onehot",
               32'($countones({GatePC, GateMDR, GateALU, GateMARMUX}) <= 1), 32'd1);
         check("oe_we_excl", 32'(Mem_OE && Mem_WE), 32'd0);
      end
   end

   initial begin
      Reset = 1'b0; Run = 1'b0; Continue = 1'b0; Opcode = 4'h0;
      IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
      step();
      step();
      chk_state("rst_hold", StHalted, 26'h0);
      Reset = 1'b1;
      mon_en = 1'b1;
      step();
      chk_state("halt_norun", StHalted, 26'h0);
      Run = 1'b1;
      step();
      chk_state("run_s18", St18, O18);
      Run = 1'b0;
      step();
      chk_state("pre_rst_s33", St33, O33);

      // Reset falling in the middle of a read access.
      #1 Reset = 1'b0;
      #1 check("rst_async_oe", 32'(Mem_OE), 32'd0);
      step();
      chk_state("rst_mid", StHalted, 26'h0);
      Reset = 1'b1;
      Run = 1'b1;
      step();
      Run = 1'b0;

      // ADD with immediate
      IR_5 = 1'b1;
      fetch(OpAdd);
      step();
      chk_state("add_s1", St1, EX | M_G_ALU | M_LD_REG | M_LD_CC);
      step();

      // BR not taken, then taken
      BEN = 1'b0;
      fetch(OpBr);
      step();
      chk_state("br_s0_nt", St0, EX);
      step();
      BEN = 1'b1;
      fetch(OpBr);
      step();
      chk_state("br_s0_t", St0, EX);
      step();
      chk_state("br_s22", St22, EX | A2_OFF9 | P_ADDER | M_LD_PC);
      step();

      // STR
      fetch(OpStr);
      step();
      chk_state("str_s7", St7, EX | M_ADDR1 | A2_OFF6 | M_G_MMUX | M_LD_MAR);
      step();
      chk_state("str_s23", St23, M_DR | K_PASS | M_G_ALU | M_LD_MDR);
      step();
      chk_state("str_s16_w0", St16, EX | M_WE);
      step();
      chk_state("str_s16_w1", St16, EX | M_WE);
      step();

      // JMP
      fetch(OpJmp);
      step();
      chk_state("jmp_s12", St12, EX | K_PASS | M_G_ALU | P_BUS | M_LD_PC);
      step();

      // JSR (PC-relative)
      IR_11 = 1'b1;
      fetch(OpJsr);
      step();
      chk_state("jsr_s4", St4, M_SR1 | M_G_PC | M_LD_REG);
      step();
      chk_state("jsr_s21", St21, EX | A2_OFF11 | P_ADDER | M_LD_PC);
      step();

      // LDR
      fetch(OpLdr);
      step();
      chk_state("ldr_s6", St6, EX | M_ADDR1 | A2_OFF6 | M_G_MMUX | M_LD_MAR);
      step();
      chk_state("ldr_s25_w0", St25, EX | O33);
      step();
      chk_state("ldr_s25_w1", St25, EX | O33 | M_LD_MDR);
      step();
      chk_state("ldr_s27", St27, EX | M_G_MDR | M_LD_REG | M_LD_CC);
      step();

      // Unused opcode behaves as NOP
      fetch(4'b1111);
      step();

      // PAUSE: one Continue press releases exactly one instruction
      fetch(OpPause);
      step();
      chk_state("p1", StP1, EX | M_LD_LED);
      step();
      chk_state("p1_hold", StP1, EX | M_LD_LED);
      Continue = 1'b1;
      step();
      chk_state("p2", StP2, EX);
      step();
      chk_state("p2_hold", StP2, EX);
      Continue = 1'b0;
      step();
      chk_state("p_ret_s18", St18, O18);
      step();
      chk_state("p_ret_s33", St33, O33);

      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
